// File: rtl/sr_fp_pkg.sv
// Shared single-precision FP definitions for the sequential arithmetic blocks.
// Field positions, special result words and the common FSM state encoding.
package sr_fp_pkg;

    localparam int SR_SIGN_BIT = 31;
    localparam int SR_EXP_MSB  = 30;
    localparam int SR_EXP_LSB  = 23;
    localparam int SR_MAN_MSB  = 22;
    localparam int SR_MAN_LSB  = 0;

    localparam logic [31:0] SR_ZERO = 32'h0000_0000;
    localparam logic [31:0] SR_NAN  = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        SR_IDLE  = 3'd0,
        SR_ALIGN = 3'd1,
        SR_SUB   = 3'd2,
        SR_NORM  = 3'd3,
        SR_DONE  = 3'd4
    } sr_state_e;

endpackage

// File: rtl/sr_fp_unpack.sv
// Splits an FP32 word into sign, exponent and 24-bit mantissa with hidden one.
// Combinational; an exponent field of zero is reported as zero.
module sr_fp_unpack
    import sr_fp_pkg::*;
(
    input  logic [31:0] word_i,
    output logic        sign_o,
    output logic [7:0]  exp_o,
    output logic [23:0] man_o,
    output logic        zero_o
);

    assign sign_o = word_i[SR_SIGN_BIT];
    assign exp_o  = word_i[SR_EXP_MSB:SR_EXP_LSB];
    assign man_o  = {1'b1, word_i[SR_MAN_MSB:SR_MAN_LSB]};
    assign zero_o = (exp_o == 8'd0);

endmodule

// File: rtl/srsub_seq.sv
// Multi-cycle same-sign FP32 magnitude subtractor z = a - b, truncating, iterative normalize.
// Latency 1 (special), 2 (exact cancel), 3+k (k normalize shifts); result held until out_ready.
module srsub_seq
    import sr_fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] z,
    output logic        err
);

    sr_state_e   state_q;
    logic [31:0] a_q, b_q, z_q;
    logic        err_q, sign_q;
    logic [7:0]  e_q;
    logic [25:0] ml_q, ms_q, m_q;

    logic        sa, sb, za, zb;
    logic [7:0]  ea, eb;
    logic [23:0] mna, mnb;

    sr_fp_unpack u_unpack_a (.word_i(a_q), .sign_o(sa), .exp_o(ea), .man_o(mna), .zero_o(za));
    sr_fp_unpack u_unpack_b (.word_i(b_q), .sign_o(sb), .exp_o(eb), .man_o(mnb), .zero_o(zb));

    logic        b_gt, rsign;
    logic [7:0]  el, es, ediff;
    logic [23:0] man_l, man_s;
    logic [30:0] big_mag;
    logic [25:0] ms_shift, m_diff;

    // The magnitude compare picks the larger operand so the difference never goes negative.
    always_comb begin
        b_gt    = (b_q[30:0] > a_q[30:0]);
        rsign   = b_gt ? ~sa : sa;
        el      = b_gt ? eb : ea;
        es      = b_gt ? ea : eb;
        man_l   = b_gt ? mnb : mna;
        man_s   = b_gt ? mna : mnb;
        big_mag = b_gt ? b_q[30:0] : a_q[30:0];
        ediff   = el - es;
        ms_shift = {man_s, 2'b00} >> ediff;
        m_diff  = ml_q - ms_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SR_IDLE;
            a_q     <= SR_ZERO;
            b_q     <= SR_ZERO;
            z_q     <= SR_ZERO;
            err_q   <= 1'b0;
            sign_q  <= 1'b0;
            e_q     <= 8'd0;
            ml_q    <= 26'd0;
            ms_q    <= 26'd0;
            m_q     <= 26'd0;
        end else begin
            case (state_q)
                SR_IDLE: begin
                    if (in_valid) begin
                        a_q     <= a;
                        b_q     <= b;
                        err_q   <= 1'b0;
                        state_q <= SR_ALIGN;
                    end
                end
                SR_ALIGN: begin
                    if (sa != sb) begin
                        z_q     <= SR_NAN;
                        err_q   <= 1'b1;
                        state_q <= SR_DONE;
                    end else if (zb) begin
                        z_q     <= a_q;
                        state_q <= SR_DONE;
                    end else if (za) begin
                        z_q     <= {~sb, b_q[30:0]};
                        state_q <= SR_DONE;
                    end else if (ediff > 8'd25) begin
                        z_q     <= {rsign, big_mag};
                        state_q <= SR_DONE;
                    end else begin
                        sign_q  <= rsign;
                        e_q     <= el;
                        ml_q    <= {man_l, 2'b00};
                        ms_q    <= ms_shift;
                        state_q <= SR_SUB;
                    end
                end
                SR_SUB: begin
                    if (m_diff == 26'd0) begin
                        z_q     <= SR_ZERO;
                        state_q <= SR_DONE;
                    end else begin
                        m_q     <= m_diff;
                        state_q <= SR_NORM;
                    end
                end
                SR_NORM: begin
                    if (m_q[25]) begin
                        z_q     <= {sign_q, e_q, m_q[24:2]};
                        state_q <= SR_DONE;
                    end else if (e_q == 8'd1) begin
                        z_q     <= SR_ZERO;
                        state_q <= SR_DONE;
                    end else begin
                        m_q <= {m_q[24:0], 1'b0};
                        e_q <= e_q - 8'd1;
                    end
                end
                SR_DONE: begin
                    if (out_ready) state_q <= SR_IDLE;
                end
                default: state_q <= SR_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == SR_IDLE);
    assign out_valid = (state_q == SR_DONE);
    assign z         = z_q;
    assign err       = err_q;

endmodule

// File: tb/tb_srsub_seq.sv
// Directed-vector bench for srsub_seq: results, error flag, latency, backpressure, async reset.
module tb_srsub_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] z;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    srsub_seq dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .z(z), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one operand pair and returns the number of edges from accept to out_valid.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, output int lat);
        @(negedge clk);
        a = op_a;
        b = op_b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) chk("timeout", 32'd0, 32'd1);
    endtask

    task automatic take_result();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    typedef struct {
        string       tag;
        logic [31:0] va, vb, vz;
        logic        verr;
        int          vlat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        vecs.push_back('{"1.5-1.0",    32'h3FC00000, 32'h3F800000, 32'h3F000000, 1'b0, 4});
        vecs.push_back('{"3.0-1.0",    32'h40400000, 32'h3F800000, 32'h40000000, 1'b0, 3});
        vecs.push_back('{"1.0-2.0",    32'h3F800000, 32'h40000000, 32'hBF800000, 1'b0, 4});
        vecs.push_back('{"cancel",     32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 2});
        vecs.push_back('{"sign_err",   32'h3F800000, 32'hBF800000, 32'hFFFFFFFF, 1'b1, 1});
        vecs.push_back('{"ediff30",    32'h4E800000, 32'h3F800000, 32'h4E800000, 1'b0, 1});
        vecs.push_back('{"a_zero",     32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1});
        vecs.push_back('{"b_zero",     32'h3F800000, 32'h00000000, 32'h3F800000, 1'b0, 1});
        vecs.push_back('{"ediff25",    32'h4C000000, 32'h3F800000, 32'h4BFFFFFF, 1'b0, 4});
        vecs.push_back('{"underflow",  32'h00C00000, 32'h00800000, 32'h00000000, 1'b0, 3});

        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_z", z, 32'h0);
        chk("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, lat);
            chk({vecs[i].tag, "_z"}, z, vecs[i].vz);
            chk({vecs[i].tag, "_err"}, {31'd0, err}, {31'd0, vecs[i].verr});
            chk({vecs[i].tag, "_lat"}, lat, vecs[i].vlat);
            take_result();
        end

        // Result must hold while the consumer stalls.
        run_op(32'h3FC00000, 32'h3F800000, lat);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_z", z, 32'h3F000000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        take_result();
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        run_op(32'h40400000, 32'h3F800000, lat);
        chk("b2b_z", z, 32'h40000000);
        chk("b2b_lat", lat, 3);
        take_result();

        // Long normalize run; reset lands in the middle of it.
        @(negedge clk);
        a = 32'h4B800000;
        b = 32'h4B7FFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        chk("pre_rst_out_valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_z", z, 32'h0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_rst_z", z, 32'h0);
        run_op(32'h40400000, 32'h3F800000, lat);
        chk("post_rst_op_z", z, 32'h40000000);
        chk("post_rst_op_lat", lat, 3);
        take_result();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
